// File: rtl/cfg_word_packer_pkg.sv
// Shared configuration-path definitions.
// Holds the packer FSM state encoding, the position of the layer-count field
// inside the network header, and the helpers that derive beat-per-word and
// layer-count widths. The CCU imports the same package so header and word
// layout are defined once.
package cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAD  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FNH   = 3'd4
  } cfg_state_e;

  // Layer count sits in the low bits of the header beat.
  localparam int HDR_NL_LSB = 0;

  function automatic int cfg_beats(input int cfg_width, input int in_width);
    return cfg_width / in_width;
  endfunction

  // Width that can hold 0..max_layer.
  function automatic int cfg_nl_width(input int max_layer);
    return $clog2(max_layer + 1);
  endfunction

endpackage

// File: rtl/cfg_word_packer_out_slot.sv
// Single-entry valid/ready output register.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_load      capture i_dat this edge (caller only loads when o_free)
//   i_dat       word to capture
//   i_rdy       downstream ready
//   o_vld       slot holds a word
//   o_dat       held word, stable until accepted
//   o_free      slot is empty or is being accepted this cycle
module cfg_out_slot #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_dat,
  input  logic         i_rdy,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  output logic         o_free
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else begin
      if (i_load) begin
        r_vld <= 1'b1;
        r_dat <= i_dat;
      end else if (r_vld && i_rdy) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_dat  = r_dat;
  assign o_free = !r_vld || i_rdy;

endmodule

// File: rtl/cfg_word_packer.sv
// Network configuration packer: turns a header plus narrow interface beats
// into full-width layer-config words for the CCU configuration FIFO.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   ITFCFG_Start     pulse, begins a network load (ignored unless idle)
//   ITFCFG_Dat/Vld   interface beat and its valid
//   CFGITF_DatRdy    beat ready (combinational)
//   CFGCCU_Dat/Vld   assembled word and its valid
//   CCUCFG_DatRdy    CCU FIFO ready
//   CFGITF_Fnh       pulse, all layer words delivered
//   CFGITF_Err       pulse, illegal layer count in header
//   CFG_Busy         load in progress
//
// state | meaning
// IDLE  | waiting for start, no beats accepted
// HEAD  | next beat is the header carrying the layer count
// LOAD  | packing beats into words, handing words to the output slot
// DRAIN | last word sits in the output slot, waiting for acceptance
// FNH   | one-cycle finish pulse
module cfg_word_packer
  import cfg_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int CFG_WIDTH = 256,
  parameter int MAX_LAYER = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ITFCFG_Start,
  input  logic [IN_WIDTH-1:0]  ITFCFG_Dat,
  input  logic                 ITFCFG_DatVld,
  output logic                 CFGITF_DatRdy,
  output logic [CFG_WIDTH-1:0] CFGCCU_Dat,
  output logic                 CFGCCU_DatVld,
  input  logic                 CCUCFG_DatRdy,
  output logic                 CFGITF_Fnh,
  output logic                 CFGITF_Err,
  output logic                 CFG_Busy
);

  localparam int BEATS = cfg_beats(CFG_WIDTH, IN_WIDTH);
  localparam int BCW   = $clog2(BEATS);
  localparam int LCW   = cfg_nl_width(MAX_LAYER);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [LCW-1:0] NL_MAX    = LCW'(MAX_LAYER);

  cfg_state_e           r_state;
  logic [BCW-1:0]       r_beat_cnt;
  logic [LCW-1:0]       r_word_cnt;
  logic [LCW-1:0]       r_nl;
  logic [CFG_WIDTH-1:0] r_asm;
  logic                 r_asm_full;
  logic                 r_busy;
  logic                 r_fnh;
  logic                 r_err;

  logic                 w_beat_xfer;
  logic                 w_last_beat;
  logic                 w_last_word;
  logic                 w_load;
  logic                 w_slot_free;
  logic                 w_slot_vld;
  logic [LCW-1:0]       w_hdr_nl;
  logic [CFG_WIDTH-1:0] w_asm_next;
  logic [CFG_WIDTH-1:0] w_load_dat;
  logic [CFG_WIDTH-1:0] w_slot_dat;

  assign w_hdr_nl = ITFCFG_Dat[HDR_NL_LSB +: LCW];

  // Word currently in assembly is the last one of the network.
  assign w_last_word = (r_word_cnt + LCW'(1)) == r_nl;

  // A complete word waiting for the slot blocks further beats. Once the slot
  // frees, the next word may start in the same cycle unless this was the last.
  always_comb begin
    CFGITF_DatRdy = 1'b0;
    case (r_state)
      ST_HEAD: CFGITF_DatRdy = 1'b1;
      ST_LOAD: CFGITF_DatRdy = r_asm_full ? (w_slot_free && !w_last_word) : 1'b1;
      default: CFGITF_DatRdy = 1'b0;
    endcase
  end

  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[r_beat_cnt*IN_WIDTH +: IN_WIDTH] = ITFCFG_Dat;
  end

  assign w_beat_xfer = ITFCFG_DatVld && CFGITF_DatRdy;
  assign w_last_beat = w_beat_xfer && (r_state == ST_LOAD) && (r_beat_cnt == LAST_BEAT);
  assign w_load      = (r_state == ST_LOAD) && w_slot_free && (r_asm_full || w_last_beat);
  // Final beat bypasses the assembly register straight into the slot.
  assign w_load_dat  = r_asm_full ? r_asm : w_asm_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_word_cnt <= '0;
      r_nl       <= '0;
      r_asm      <= '0;
      r_asm_full <= 1'b0;
      r_busy     <= 1'b0;
      r_fnh      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_fnh <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ITFCFG_Start) begin
            r_state <= ST_HEAD;
            r_busy  <= 1'b1;
          end
        end
        ST_HEAD: begin
          if (w_beat_xfer) begin
            if (w_hdr_nl == '0 || w_hdr_nl > NL_MAX) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_nl       <= w_hdr_nl;
              r_word_cnt <= '0;
              r_beat_cnt <= '0;
              r_asm_full <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (w_beat_xfer) begin
            r_asm      <= w_asm_next;
            r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + BCW'(1);
          end
          if (w_last_beat && !w_slot_free) begin
            r_asm_full <= 1'b1;
          end else if (w_load) begin
            r_asm_full <= 1'b0;
          end
          if (w_load) begin
            r_word_cnt <= r_word_cnt + LCW'(1);
            if (w_last_word) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_slot_vld && CCUCFG_DatRdy) begin
            r_state <= ST_FNH;
            r_busy  <= 1'b0;
            r_fnh   <= 1'b1;
          end
        end
        ST_FNH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  cfg_out_slot #(
    .W (CFG_WIDTH)
  ) u_out_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_dat  (w_load_dat),
    .i_rdy  (CCUCFG_DatRdy),
    .o_vld  (w_slot_vld),
    .o_dat  (w_slot_dat),
    .o_free (w_slot_free)
  );

  assign CFGCCU_Dat    = w_slot_dat;
  assign CFGCCU_DatVld = w_slot_vld;
  assign CFGITF_Fnh    = r_fnh;
  assign CFGITF_Err    = r_err;
  assign CFG_Busy      = r_busy;

endmodule

// File: tb/tb_cfg_word_packer.sv
// Directed bench for cfg_word_packer: legal load, backpressure, illegal
// headers, bubbly input, start-while-busy, reset mid-load, and overlap of
// word acceptance with the last beat of the next word.
module tb_cfg_word_packer;

  logic         clk;
  logic         rst_n;
  logic         ITFCFG_Start;
  logic [31:0]  ITFCFG_Dat;
  logic         ITFCFG_DatVld;
  logic         CFGITF_DatRdy;
  logic [255:0] CFGCCU_Dat;
  logic         CFGCCU_DatVld;
  logic         CCUCFG_DatRdy;
  logic         CFGITF_Fnh;
  logic         CFGITF_Err;
  logic         CFG_Busy;

  int checks = 0;
  int errors = 0;

  logic [255:0] got_q[$];
  int fnh_cnt = 0;
  int err_cnt = 0;
  int vld_cnt = 0;

  cfg_word_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ITFCFG_Start  (ITFCFG_Start),
    .ITFCFG_Dat    (ITFCFG_Dat),
    .ITFCFG_DatVld (ITFCFG_DatVld),
    .CFGITF_DatRdy (CFGITF_DatRdy),
    .CFGCCU_Dat    (CFGCCU_Dat),
    .CFGCCU_DatVld (CFGCCU_DatVld),
    .CCUCFG_DatRdy (CCUCFG_DatRdy),
    .CFGITF_Fnh    (CFGITF_Fnh),
    .CFGITF_Err    (CFGITF_Err),
    .CFG_Busy      (CFG_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; sample mid-low-phase, before the
  // rising edge that consumes them.
  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      if (CFGCCU_DatVld && CCUCFG_DatRdy) got_q.push_back(CFGCCU_Dat);
      if (CFGITF_Fnh) fnh_cnt++;
      if (CFGITF_Err) err_cnt++;
      if (CFGCCU_DatVld) vld_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_word(input logic [31:0] base);
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = base + 32'(k);
    return w;
  endfunction

  task automatic clear_log();
    got_q.delete();
    fnh_cnt = 0;
    err_cnt = 0;
    vld_cnt = 0;
  endtask

  task automatic pulse_start();
    ITFCFG_Start = 1'b1;
    @(negedge clk);
    ITFCFG_Start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d);
    int n;
    n = 0;
    ITFCFG_Dat    = d;
    ITFCFG_DatVld = 1'b1;
    #1;
    while (!CFGITF_DatRdy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!CFGITF_DatRdy) chk("beat_rdy_timeout", {255'd0, CFGITF_DatRdy}, 256'd1);
    @(negedge clk);
    ITFCFG_DatVld = 1'b0;
  endtask

  task automatic wait_fnh(input string tag);
    int n;
    n = 0;
    while (!CFGITF_Fnh && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!CFGITF_Fnh) chk(tag, {255'd0, CFGITF_Fnh}, 256'd1);
  endtask

  logic [255:0] w0, w1, w2;
  logic [31:0]  bv;
  logic         hold_ok;

  initial begin
    rst_n         = 1'b0;
    ITFCFG_Start  = 1'b0;
    ITFCFG_Dat    = '0;
    ITFCFG_DatVld = 1'b0;
    CCUCFG_DatRdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs", {250'd0, CFGITF_DatRdy, CFGCCU_DatVld, CFGITF_Fnh, CFGITF_Err, CFG_Busy, 1'b0}, 256'd0);
    chk("rst_dat", CFGCCU_Dat, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Legal load NL=2, no backpressure, with an ignored start mid-load
    clear_log();
    w0 = mk_word(32'h1);
    w1 = mk_word(32'h9);
    pulse_start();
    chk("t1_busy", {255'd0, CFG_Busy}, 256'd1);
    chk("t1_head_rdy", {255'd0, CFGITF_DatRdy}, 256'd1);
    send_beat(32'd2);
    for (int i = 1; i <= 4; i++) send_beat(32'(i));
    pulse_start();
    for (int i = 5; i <= 7; i++) send_beat(32'(i));
    chk("t1_vld_before", {255'd0, CFGCCU_DatVld}, 256'd0);
    send_beat(32'd8);
    chk("t1_vld_w0", {255'd0, CFGCCU_DatVld}, 256'd1);
    chk("t1_dat_w0", CFGCCU_Dat, w0);
    for (int i = 9; i <= 16; i++) send_beat(32'(i));
    chk("t1_vld_w1", {255'd0, CFGCCU_DatVld}, 256'd1);
    chk("t1_dat_w1", CFGCCU_Dat, w1);
    @(negedge clk);
    chk("t1_fnh", {254'd0, CFGITF_Fnh, CFG_Busy}, 256'd2);
    @(negedge clk);
    chk("t1_fnh_gone", {255'd0, CFGITF_Fnh}, 256'd0);
    chk("t1_nwords", 256'(got_q.size()), 256'd2);
    if (got_q.size() == 2) begin
      chk("t1_got0", got_q[0], w0);
      chk("t1_got1", got_q[1], w1);
    end
    chk("t1_fnh_cnt", 256'(fnh_cnt), 256'd1);

    // Backpressure NL=3
    clear_log();
    w0 = mk_word(32'hA000_0001);
    w1 = mk_word(32'hA000_0009);
    w2 = mk_word(32'hA000_0011);
    CCUCFG_DatRdy = 1'b0;
    pulse_start();
    send_beat(32'd3);
    for (int i = 0; i < 15; i++) send_beat(32'hA000_0001 + 32'(i));
    chk("t2_rdy_b15", {255'd0, CFGITF_DatRdy}, 256'd1);
    send_beat(32'hA000_0010);
    chk("t2_rdy_drop", {255'd0, CFGITF_DatRdy}, 256'd0);
    chk("t2_dat_w0", CFGCCU_Dat, w0);
    hold_ok = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (!(CFGCCU_DatVld === 1'b1 && CFGCCU_Dat === w0 && CFGITF_DatRdy === 1'b0)) hold_ok = 1'b0;
      @(negedge clk);
    end
    chk("t2_hold", {255'd0, hold_ok}, 256'd1);
    CCUCFG_DatRdy = 1'b1;
    for (int i = 16; i < 24; i++) send_beat(32'hA000_0001 + 32'(i));
    wait_fnh("t2_fnh_timeout");
    repeat (2) @(negedge clk);
    chk("t2_nwords", 256'(got_q.size()), 256'd3);
    if (got_q.size() == 3) begin
      chk("t2_got0", got_q[0], w0);
      chk("t2_got1", got_q[1], w1);
      chk("t2_got2", got_q[2], w2);
    end
    chk("t2_fnh_cnt", 256'(fnh_cnt), 256'd1);

    // Illegal headers NL=0 (upper bits set) and NL=17
    clear_log();
    pulse_start();
    send_beat(32'hFFFF_FFE0);
    chk("t3a_err", {253'd0, CFGITF_Err, CFG_Busy, CFGITF_DatRdy}, 256'd4);
    @(negedge clk);
    chk("t3a_err_gone", {255'd0, CFGITF_Err}, 256'd0);
    pulse_start();
    send_beat(32'h0000_0011);
    chk("t3b_err", {253'd0, CFGITF_Err, CFG_Busy, CFGITF_DatRdy}, 256'd4);
    repeat (2) @(negedge clk);
    chk("t3_err_cnt", 256'(err_cnt), 256'd2);
    chk("t3_no_vld", 256'(vld_cnt), 256'd0);
    chk("t3_no_fnh", 256'(fnh_cnt), 256'd0);

    // Bubbly input NL=1, header upper bits ignored
    clear_log();
    pulse_start();
    send_beat(32'h1234_5661);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      bv = $urandom;
      w0[k*32 +: 32] = bv;
      send_beat(bv);
    end
    wait_fnh("t4_fnh_timeout");
    repeat (2) @(negedge clk);
    chk("t4_nwords", 256'(got_q.size()), 256'd1);
    if (got_q.size() == 1) chk("t4_got0", got_q[0], w0);
    chk("t4_fnh_cnt", 256'(fnh_cnt), 256'd1);

    // Reset after 5 beats of word0
    clear_log();
    pulse_start();
    send_beat(32'd2);
    for (int i = 0; i < 5; i++) send_beat(32'hBEEF_0000 + 32'(i));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", {250'd0, CFGITF_DatRdy, CFGCCU_DatVld, CFGITF_Fnh, CFGITF_Err, CFG_Busy, 1'b0}, 256'd0);
    chk("t5_rst_dat", CFGCCU_Dat, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_rdy", {255'd0, CFGITF_DatRdy}, 256'd0);
    w0 = mk_word(32'h5000_0001);
    pulse_start();
    send_beat(32'd1);
    for (int i = 0; i < 8; i++) send_beat(32'h5000_0001 + 32'(i));
    wait_fnh("t5_fnh_timeout");
    repeat (2) @(negedge clk);
    chk("t5_nwords", 256'(got_q.size()), 256'd1);
    if (got_q.size() == 1) chk("t5_got0", got_q[0], w0);
    chk("t5_cnts", {254'd0, 1'(fnh_cnt), 1'(err_cnt)}, 256'd2);

    // Word0 accepted in the same cycle as word1's last beat
    clear_log();
    w0 = mk_word(32'h7700_0001);
    w1 = mk_word(32'h7700_0009);
    CCUCFG_DatRdy = 1'b0;
    pulse_start();
    send_beat(32'd2);
    for (int i = 0; i < 15; i++) send_beat(32'h7700_0001 + 32'(i));
    chk("t6_w0_held", CFGCCU_Dat, w0);
    CCUCFG_DatRdy = 1'b1;
    send_beat(32'h7700_0010);
    chk("t6_vld_w1", {255'd0, CFGCCU_DatVld}, 256'd1);
    chk("t6_dat_w1", CFGCCU_Dat, w1);
    wait_fnh("t6_fnh_timeout");
    repeat (2) @(negedge clk);
    chk("t6_nwords", 256'(got_q.size()), 256'd2);
    if (got_q.size() == 2) begin
      chk("t6_got0", got_q[0], w0);
      chk("t6_got1", got_q[1], w1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
